// File: rtl/hamming_serial_tx.sv
// Serial line transmitter for Hamming(7,4) codewords.
// Codewords are buffered in a small circular FIFO and each one is sent as a
// UART-style frame: one low start bit, CW_WIDTH data bits LSB first, and one
// high stop bit, each bit held for BIT_CYCLES clocks. Back-to-back frames are
// sent with no idle gap when the FIFO already holds the next codeword.
module hamming_serial_tx #(
  parameter int CW_WIDTH   = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CW_WIDTH-1:0]           in_codeword,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (CW_WIDTH   > 1) ? $clog2(CW_WIDTH)   : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CW_WIDTH - 1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]          state_q,   state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]       idx_q,     idx_d;
  logic [CW_WIDTH-1:0] shreg_q,   shreg_d;
  logic [PW-1:0]       wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q,  rd_ptr_d;
  logic [PW:0]         count_q,   count_d;
  logic                tx_line_q, tx_line_d;
  logic                tx_busy_q, tx_busy_d;
  logic                frame_done_q, frame_done_d;
  logic [CW_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CW_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic push, pop, bit_last;

  // Ready depends on occupancy only, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q != CNT_FULL);
  assign push     = in_valid & in_ready;
  assign bit_last = (bit_cnt_q == BIT_LAST);

  // FSM, FIFO bookkeeping and next-value of the registered line outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shreg_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: begin // S_STOP
        if (bit_last) begin
          bit_cnt_d = '0;
          // Chain straight into the next frame when one is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = in_codeword;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // Outputs are registered from the next state so the line changes on the
    // same edge the FSM does.
    case (state_d)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = shreg_d[idx_d];
      default: tx_line_d = 1'b1;
    endcase
    tx_busy_d    = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (bit_cnt_d == BIT_LAST);
  end

  // State registers; reset aborts any frame and discards buffered codewords.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_line_q    <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_line_q    <= tx_line_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
      mem_q        <= mem_d;
    end
  end

  assign tx_line    = tx_line_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Directed bench for hamming_serial_tx at default parameters.
module tb_hamming_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] in_codeword;
  logic       in_valid;
  logic       in_ready;
  logic       tx_line;
  logic       tx_busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic ln_log [0:199];
  logic fd_log [0:199];
  logic bz_log [0:199];

  hamming_serial_tx #(.CW_WIDTH(7), .FIFO_DEPTH(4), .BIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_codeword(in_codeword), .in_valid(in_valid),
    .in_ready(in_ready), .tx_line(tx_line), .tx_busy(tx_busy),
    .frame_done(frame_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line for one frame: bit k is tx_line k cycles after the frame starts.
  function automatic logic [35:0] exp_frame(input logic [6:0] cw);
    logic [35:0] f;
    for (int k = 0; k < 36; k++) begin
      if (k < 4)       f[k] = 1'b0;
      else if (k < 32) f[k] = cw[(k-4)/4];
      else             f[k] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [6:0] ham_enc(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  // Record 36 consecutive samples starting with the current one.
  task automatic capture(output logic [35:0] ln, output logic [35:0] fd);
    for (int k = 0; k < 36; k++) begin
      ln[k] = tx_line;
      fd[k] = frame_done;
      step();
    end
  endtask

  // Push one word from idle, wait (bounded) for the start bit, capture the frame.
  task automatic send_frame(input logic [6:0] cw, output logic [35:0] ln,
                            output logic [35:0] fd, output logic ok);
    in_codeword = cw;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    ok = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (tx_line === 1'b0) begin ok = 1'b1; break; end
      step();
    end
    ln = '1;
    fd = '0;
    if (ok) capture(ln, fd);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_codeword = '0;
    step(); step();
    total++;
    if ({tx_line, in_ready, tx_busy, frame_done, fifo_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_state got line=%b rdy=%b busy=%b fd=%b cnt=%0d exp 1 1 0 0 0",
               tx_line, in_ready, tx_busy, frame_done, fifo_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    logic [35:0] ln, fd;
    in_codeword = 7'b1011010;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({tx_line, tx_busy, fifo_count} !== {1'b1, 1'b0, 3'd1}) begin
      bad++;
      $display("FAIL single_after_push got line=%b busy=%b cnt=%0d exp 1 0 1", tx_line, tx_busy, fifo_count);
    end
    step();
    total++;
    if ({tx_line, tx_busy, fifo_count} !== {1'b0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL single_latency got line=%b busy=%b cnt=%0d exp 0 1 0", tx_line, tx_busy, fifo_count);
    end
    capture(ln, fd);
    total++;
    if (ln !== exp_frame(7'b1011010)) begin
      bad++;
      $display("FAIL single_line got=%h exp=%h", ln, exp_frame(7'b1011010));
    end
    total++;
    if (fd !== 36'h8_0000_0000) begin
      bad++;
      $display("FAIL single_frame_done got=%h exp=%h", fd, 36'h8_0000_0000);
    end
    total++;
    if ({tx_line, tx_busy, frame_done} !== {1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL single_idle got line=%b busy=%b fd=%b exp 1 0 0", tx_line, tx_busy, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] words [6];
    logic [35:0] ln;
    int nfd;
    logic busy_gap;
    words = '{7'h15, 7'h2A, 7'h33, 7'h4C, 7'h01, 7'h7F};
    for (int i = 0; i < 6; i++) begin
      in_codeword = words[i];
      in_valid    = 1'b1;
      total++;
      if (in_ready !== (i < 5)) begin
        bad++;
        $display("FAIL b2b_in_ready cycle %0d got=%b exp=%b", i, in_ready, (i < 5));
      end
      step();
      ln_log[i] = tx_line; fd_log[i] = frame_done; bz_log[i] = tx_busy;
    end
    in_valid = 1'b0;
    for (int i = 6; i < 184; i++) begin
      step();
      ln_log[i] = tx_line; fd_log[i] = frame_done; bz_log[i] = tx_busy;
    end
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 36; k++) ln[k] = ln_log[1 + 36*j + k];
      total++;
      if (ln !== exp_frame(words[j])) begin
        bad++;
        $display("FAIL b2b_frame%0d got=%h exp=%h", j, ln, exp_frame(words[j]));
      end
    end
    nfd = 0;
    for (int i = 0; i < 184; i++) if (fd_log[i] === 1'b1) nfd++;
    total++;
    if (nfd !== 5 || fd_log[36] !== 1'b1 || fd_log[180] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_frame_done got count=%0d fd36=%b fd180=%b exp 5 1 1", nfd, fd_log[36], fd_log[180]);
    end
    busy_gap = 1'b0;
    for (int i = 1; i <= 180; i++) if (bz_log[i] !== 1'b1) busy_gap = 1'b1;
    total++;
    if (busy_gap !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy_gap got=%b exp=0", busy_gap);
    end
    total++;
    if ({ln_log[181], bz_log[181], fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL b2b_end got line=%b busy=%b cnt=%0d exp 1 0 0", ln_log[181], bz_log[181], fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [35:0] ln, fd;
    logic ok, stray;
    logic [6:0] a;
    a = 7'b0001000;
    in_codeword = a;       in_valid = 1'b1; step();
    in_codeword = 7'h66;   step();
    in_valid = 1'b0;
    for (int k = 0; k < 17; k++) step();
    total++;
    if ({tx_line, tx_busy} !== {a[3], 1'b1}) begin
      bad++;
      $display("FAIL midrst_pre got line=%b busy=%b exp %b 1", tx_line, tx_busy, a[3]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({tx_line, fifo_count, tx_busy, frame_done} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_post got line=%b cnt=%0d busy=%b fd=%b exp 1 0 0 0",
               tx_line, fifo_count, tx_busy, frame_done);
    end
    stray = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (tx_line !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet got=%b exp=0", stray);
    end
    send_frame(7'h5C, ln, fd, ok);
    total++;
    if (!ok || ln !== exp_frame(7'h5C) || fd !== 36'h8_0000_0000) begin
      bad++;
      $display("FAIL midrst_resume got ok=%b line=%h fd=%h exp 1 %h %h", ok, ln, fd,
               exp_frame(7'h5C), 36'h8_0000_0000);
    end
  endtask

  task automatic test_full_push_pop();
    logic [6:0] words [5];
    logic [35:0] ln, fd;
    logic seen;
    words = '{7'h11, 7'h22, 7'h44, 7'h08, 7'h70};
    for (int i = 0; i < 5; i++) begin
      in_codeword = words[i];
      in_valid    = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL full_fill_ready cycle %0d got=%b exp=1", i, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 60; w++) begin
      if (frame_done === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    total++;
    if (seen !== 1'b1 || fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_wait got fd=%b cnt=%0d rdy=%b exp 1 4 0", seen, fifo_count, in_ready);
    end
    in_codeword = 7'h55;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (fifo_count !== 3'd3) begin
      bad++;
      $display("FAIL full_refused got cnt=%0d exp=3", fifo_count);
    end
    for (int f = 1; f < 5; f++) begin
      capture(ln, fd);
      total++;
      if (ln !== exp_frame(words[f]) || fd !== 36'h8_0000_0000) begin
        bad++;
        $display("FAIL full_frame%0d got line=%h fd=%h exp %h %h", f, ln, fd,
                 exp_frame(words[f]), 36'h8_0000_0000);
      end
    end
    total++;
    if ({tx_busy, tx_line, fifo_count} !== {1'b0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL full_end got busy=%b line=%b cnt=%0d exp 0 1 0", tx_busy, tx_line, fifo_count);
    end
  endtask

  task automatic test_loopback();
    logic [35:0] ln, fd;
    logic ok;
    logic [6:0] rx;
    logic [2:0] syn;
    logic [3:0] dec;
    for (int d = 0; d < 16; d++) begin
      send_frame(ham_enc(4'(d)), ln, fd, ok);
      // Deserialize at the middle of each bit period.
      for (int b = 0; b < 7; b++) rx[b] = ln[4 + 4*b + 2];
      syn[0] = rx[0] ^ rx[2] ^ rx[4] ^ rx[6];
      syn[1] = rx[1] ^ rx[2] ^ rx[5] ^ rx[6];
      syn[2] = rx[3] ^ rx[4] ^ rx[5] ^ rx[6];
      if (syn != 3'd0) rx[syn - 3'd1] = ~rx[syn - 3'd1];
      dec = {rx[6], rx[5], rx[4], rx[2]};
      total++;
      if (!ok || dec !== 4'(d) || syn !== 3'd0 || ln[0] !== 1'b0 || ln[35] !== 1'b1) begin
        bad++;
        $display("FAIL loopback d=%0d got ok=%b dec=%0d syn=%0d start=%b stop=%b exp 1 %0d 0 0 1",
                 d, ok, dec, syn, ln[0], ln[35], d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_full_push_pop();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
